// File: rtl/mem_bus_arbiter.sv
// N-to-1 memory-port arbiter with independent round-robin read and write channels,
// burst-long grants and a read-after-write line hazard interlock.
module mem_bus_arbiter #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned HAZ_LSB   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        m_rreq,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_raddr,
    input  logic [NUM_PORTS*3-1:0]      m_rsize,
    input  logic [NUM_PORTS*LEN_W-1:0]  m_rlen,
    output logic [NUM_PORTS-1:0]        m_rgnt,
    output logic [NUM_PORTS-1:0]        m_rvalid,
    output logic [NUM_PORTS-1:0]        m_rlast,
    output logic [DATA_W-1:0]           m_rdata,
    input  logic [NUM_PORTS-1:0]        m_wreq,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_waddr,
    input  logic [NUM_PORTS*3-1:0]      m_wsize,
    input  logic [NUM_PORTS*LEN_W-1:0]  m_wlen,
    input  logic [NUM_PORTS*DATA_W-1:0] m_wdata,
    input  logic [NUM_PORTS*4-1:0]      m_wstrb,
    output logic [NUM_PORTS-1:0]        m_wgnt,
    output logic [NUM_PORTS-1:0]        m_wready,
    output logic [NUM_PORTS-1:0]        m_bdone,
    output logic                        ram_arvalid,
    input  logic                        ram_arready,
    output logic [ADDR_W-1:0]           ram_araddr,
    output logic [2:0]                  ram_arsize,
    output logic [LEN_W-1:0]            ram_arlen,
    output logic [3:0]                  ram_arid,
    input  logic                        ram_rvalid,
    input  logic                        ram_rlast,
    input  logic [3:0]                  ram_rid,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic                        ram_awvalid,
    input  logic                        ram_awready,
    output logic [ADDR_W-1:0]           ram_awaddr,
    output logic [2:0]                  ram_awsize,
    output logic [LEN_W-1:0]            ram_awlen,
    output logic                        ram_wvalid,
    input  logic                        ram_wready,
    output logic                        ram_wlast,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic [3:0]                  ram_wstrb,
    input  logic                        ram_bvalid
);
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t             r_state, r_next;
    w_state_t             w_state, w_next;
    logic [IDX_W-1:0]     r_owner, r_ptr, r_idx, w_owner, w_ptr, w_idx;
    logic [ADDR_W-1:0]    r_addr, w_addr;
    logic [2:0]           r_size, w_size;
    logic [LEN_W-1:0]     r_len, w_len, w_cnt;
    logic [NUM_PORTS-1:0] r_onehot, w_onehot, r_haz, r_cand, w_cand;
    logic                 r_found, w_found, r_beat, w_beat, w_last;

    logic [ADDR_W-1:0] raddr_a [NUM_PORTS];
    logic [ADDR_W-1:0] waddr_a [NUM_PORTS];
    logic [2:0]        rsize_a [NUM_PORTS];
    logic [2:0]        wsize_a [NUM_PORTS];
    logic [LEN_W-1:0]  rlen_a  [NUM_PORTS];
    logic [LEN_W-1:0]  wlen_a  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_a [NUM_PORTS];
    logic [3:0]        wstrb_a [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign raddr_a[g] = m_raddr[g*ADDR_W +: ADDR_W];
        assign waddr_a[g] = m_waddr[g*ADDR_W +: ADDR_W];
        assign rsize_a[g] = m_rsize[g*3 +: 3];
        assign wsize_a[g] = m_wsize[g*3 +: 3];
        assign rlen_a[g]  = m_rlen[g*LEN_W +: LEN_W];
        assign wlen_a[g]  = m_wlen[g*LEN_W +: LEN_W];
        assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
        assign wstrb_a[g] = m_wstrb[g*4 +: 4];
    end

    // First requester at or after ptr, wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [2*NUM_PORTS-1:0] rot;
        logic                   found;
        logic [IDX_W-1:0]       idx;
        rot   = {req, req} >> ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % int'(NUM_PORTS));
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_PORTS - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Read candidates on the line being (or about to be) written are held off.
    always_comb begin
        r_haz = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (w_state != W_IDLE)
                r_haz[i] = raddr_a[i][ADDR_W-1:HAZ_LSB] == w_addr[ADDR_W-1:HAZ_LSB];
            else if (w_found)
                r_haz[i] = raddr_a[i][ADDR_W-1:HAZ_LSB] == waddr_a[w_idx][ADDR_W-1:HAZ_LSB];
        end
    end

    // A port whose completion is being pulsed is still holding its request.
    assign w_cand             = m_wreq & ~m_bdone;
    assign r_cand             = m_rreq & ~r_haz;
    assign {w_found, w_idx}   = rr_pick(w_cand, w_ptr);
    assign {r_found, r_idx}   = rr_pick(r_cand, r_ptr);
    assign r_onehot           = NUM_PORTS'(1) << r_owner;
    assign w_onehot           = NUM_PORTS'(1) << w_owner;
    assign r_beat             = (r_state == R_DATA) && ram_rvalid && (ram_rid == 4'(r_owner));
    assign w_beat             = (w_state == W_DATA) && ram_wready;
    assign w_last             = (w_cnt == w_len);

    assign ram_araddr = r_addr;
    assign ram_arsize = r_size;
    assign ram_arlen  = r_len;
    assign ram_arid   = 4'(r_owner);
    assign ram_awaddr = w_addr;
    assign ram_awsize = w_size;
    assign ram_awlen  = w_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (r_found) r_next = R_ADDR;
            R_ADDR:  if (ram_arready) r_next = R_DATA;
            R_DATA:  if (r_beat && ram_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_found) w_next = W_ADDR;
            W_ADDR:  if (ram_awready) w_next = W_DATA;
            W_DATA:  if (w_beat && w_last) w_next = W_RESP;
            W_RESP:  if (ram_bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        m_rgnt      = '0;
        m_rvalid    = '0;
        m_rlast     = '0;
        m_rdata     = '0;
        ram_arvalid = 1'b0;
        if (r_state != R_IDLE) m_rgnt = r_onehot;
        if (r_state == R_ADDR) ram_arvalid = 1'b1;
        if (r_state == R_DATA) m_rdata = ram_rdata;
        if (r_beat) begin
            m_rvalid = r_onehot;
            if (ram_rlast) m_rlast = r_onehot;
        end
    end

    always_comb begin
        m_wgnt      = '0;
        m_wready    = '0;
        ram_awvalid = 1'b0;
        ram_wvalid  = 1'b0;
        ram_wlast   = 1'b0;
        ram_wdata   = '0;
        ram_wstrb   = '0;
        if (w_state != W_IDLE) m_wgnt = w_onehot;
        if (w_state == W_ADDR) ram_awvalid = 1'b1;
        if (w_state == W_DATA) begin
            ram_wvalid = 1'b1;
            ram_wlast  = w_last;
            ram_wdata  = wdata_a[w_owner];
            ram_wstrb  = wstrb_a[w_owner];
        end
        if (w_beat) m_wready = w_onehot;
    end

    // Read command latch and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_len   <= '0;
            r_ptr   <= '0;
        end else begin
            if (r_state == R_IDLE && r_found) begin
                r_owner <= r_idx;
                r_addr  <= raddr_a[r_idx];
                r_size  <= rsize_a[r_idx];
                r_len   <= rlen_a[r_idx];
            end
            if (r_beat && ram_rlast) r_ptr <= ptr_inc(r_owner);
        end
    end

    // Write command latch, beat counter, pointer and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_owner <= '0;
            w_addr  <= '0;
            w_size  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_ptr   <= '0;
            m_bdone <= '0;
        end else begin
            m_bdone <= '0;
            if (w_state == W_IDLE && w_found) begin
                w_owner <= w_idx;
                w_addr  <= waddr_a[w_idx];
                w_size  <= wsize_a[w_idx];
                w_len   <= wlen_a[w_idx];
            end
            if (w_beat) w_cnt <= w_last ? '0 : w_cnt + LEN_W'(1);
            if (w_state == W_RESP && ram_bvalid) begin
                m_bdone <= w_onehot;
                w_ptr   <= ptr_inc(w_owner);
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, read/write bursts, round-robin,
// hazard interlock, stray read IDs and reset in mid-burst.
module tb_mem_bus_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]    m_rreq, m_rgnt, m_rvalid, m_rlast;
    logic [NP*AW-1:0] m_raddr, m_waddr;
    logic [NP*3-1:0]  m_rsize, m_wsize;
    logic [NP*LW-1:0] m_rlen, m_wlen;
    logic [DW-1:0]    m_rdata;
    logic [NP-1:0]    m_wreq, m_wgnt, m_wready, m_bdone;
    logic [NP*DW-1:0] m_wdata;
    logic [NP*4-1:0]  m_wstrb;
    logic             ram_arvalid, ram_arready, ram_rvalid, ram_rlast;
    logic [AW-1:0]    ram_araddr, ram_awaddr;
    logic [2:0]       ram_arsize, ram_awsize;
    logic [LW-1:0]    ram_arlen, ram_awlen;
    logic [3:0]       ram_arid, ram_rid, ram_wstrb;
    logic [DW-1:0]    ram_rdata, ram_wdata;
    logic             ram_awvalid, ram_awready, ram_wvalid, ram_wready, ram_wlast, ram_bvalid;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rsize(m_rsize), .m_rlen(m_rlen),
        .m_rgnt(m_rgnt), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wsize(m_wsize), .m_wlen(m_wlen),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wgnt(m_wgnt), .m_wready(m_wready),
        .m_bdone(m_bdone),
        .ram_arvalid(ram_arvalid), .ram_arready(ram_arready), .ram_araddr(ram_araddr),
        .ram_arsize(ram_arsize), .ram_arlen(ram_arlen), .ram_arid(ram_arid),
        .ram_rvalid(ram_rvalid), .ram_rlast(ram_rlast), .ram_rid(ram_rid), .ram_rdata(ram_rdata),
        .ram_awvalid(ram_awvalid), .ram_awready(ram_awready), .ram_awaddr(ram_awaddr),
        .ram_awsize(ram_awsize), .ram_awlen(ram_awlen),
        .ram_wvalid(ram_wvalid), .ram_wready(ram_wready), .ram_wlast(ram_wlast),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_bvalid(ram_bvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        m_rreq = '0; m_raddr = '0; m_rsize = '0; m_rlen = '0;
        m_wreq = '0; m_waddr = '0; m_wsize = '0; m_wlen = '0;
        m_wdata = '0; m_wstrb = '0;
        ram_arready = 1'b0; ram_rvalid = 1'b0; ram_rlast = 1'b0; ram_rid = '0; ram_rdata = '0;
        ram_awready = 1'b0; ram_wready = 1'b0; ram_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m_rreq = 3'b111;
        m_wreq = 3'b111;
        tick();
        tick();
        clear_inputs();
        rst = 1'b0;
        settle();
        n_tests++;
        if ({m_rgnt, m_wgnt} !== 6'b0) begin
            n_fail++; $display("FAIL reset_gnt got %b exp 000000", {m_rgnt, m_wgnt});
        end
        n_tests++;
        if ({ram_arvalid, ram_awvalid, ram_wvalid, ram_wlast} !== 4'b0) begin
            n_fail++; $display("FAIL reset_valids got %b exp 0000", {ram_arvalid, ram_awvalid, ram_wvalid, ram_wlast});
        end
        n_tests++;
        if ({m_rvalid, m_rlast, m_wready, m_bdone} !== 12'b0) begin
            n_fail++; $display("FAIL reset_client got %b exp 0", {m_rvalid, m_rlast, m_wready, m_bdone});
        end
    endtask

    task automatic test_single_read();
        logic [2:0] el;
        do_reset();
        m_rreq[1] = 1'b1;
        m_raddr[AW +: AW] = 32'h1FC0_0010;
        m_rlen[LW +: LW] = 4'd3;
        m_rsize[3 +: 3] = 3'd2;
        settle();
        n_tests++;
        if (ram_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_arvalid_t0 got %b exp 0", ram_arvalid);
        end
        tick();
        settle();
        n_tests++;
        if ({ram_arvalid, ram_arid, ram_arlen, ram_arsize} !== {1'b1, 4'd1, 4'd3, 3'd2}) begin
            n_fail++; $display("FAIL rd_cmd got v=%b id=%0d len=%0d size=%0d exp v=1 id=1 len=3 size=2",
                               ram_arvalid, ram_arid, ram_arlen, ram_arsize);
        end
        n_tests++;
        if (ram_araddr !== 32'h1FC0_0010) begin
            n_fail++; $display("FAIL rd_araddr got %h exp 1fc00010", ram_araddr);
        end
        n_tests++;
        if (m_rgnt !== 3'b010) begin
            n_fail++; $display("FAIL rd_gnt got %b exp 010", m_rgnt);
        end
        ram_arready = 1'b1;
        tick();
        ram_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ram_rvalid = 1'b1;
            ram_rid    = 4'd1;
            ram_rlast  = (b == 3);
            ram_rdata  = 32'hA000_0000 + 32'(b);
            el = (b == 3) ? 3'b010 : 3'b000;
            settle();
            n_tests++;
            if (m_rvalid !== 3'b010 || m_rdata !== 32'hA000_0000 + 32'(b)) begin
                n_fail++; $display("FAIL rd_beat%0d got rvalid=%b data=%h exp rvalid=010 data=%h",
                                   b, m_rvalid, m_rdata, 32'hA000_0000 + 32'(b));
            end
            n_tests++;
            if (m_rlast !== el) begin
                n_fail++; $display("FAIL rd_rlast%0d got %b exp %b", b, m_rlast, el);
            end
            tick();
        end
        ram_rvalid = 1'b0;
        ram_rlast  = 1'b0;
        m_rreq[1]  = 1'b0;
        settle();
        n_tests++;
        if (m_rgnt !== 3'b000) begin
            n_fail++; $display("FAIL rd_gnt_clear got %b exp 000", m_rgnt);
        end
    endtask

    task automatic test_round_robin();
        int exp_p[4] = '{0, 1, 2, 0};
        logic [2:0] oh;
        do_reset();
        m_rreq = 3'b111;
        m_raddr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        for (int k = 0; k < 4; k++) begin
            oh = 3'b001 << exp_p[k];
            tick();
            settle();
            n_tests++;
            if (m_rgnt !== oh || ram_arid !== 4'(exp_p[k])) begin
                n_fail++; $display("FAIL rr_gnt%0d got gnt=%b id=%0d exp gnt=%b id=%0d",
                                   k, m_rgnt, ram_arid, oh, exp_p[k]);
            end
            ram_arready = 1'b1;
            tick();
            ram_arready = 1'b0;
            ram_rvalid = 1'b1;
            ram_rid    = 4'(exp_p[k]);
            ram_rlast  = 1'b1;
            settle();
            n_tests++;
            if (m_rlast !== oh) begin
                n_fail++; $display("FAIL rr_rlast%0d got %b exp %b", k, m_rlast, oh);
            end
            tick();
            ram_rvalid = 1'b0;
            ram_rlast  = 1'b0;
            if (k == 3) m_rreq = '0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_rreq[2] = 1'b1;
        m_raddr[2*AW +: AW] = 32'h0000_4000;
        for (int k = 0; k < 2; k++) begin
            tick();
            settle();
            n_tests++;
            if (m_rgnt !== 3'b100) begin
                n_fail++; $display("FAIL b2b_gnt%0d got %b exp 100", k, m_rgnt);
            end
            ram_arready = 1'b1;
            tick();
            ram_arready = 1'b0;
            ram_rvalid = 1'b1; ram_rid = 4'd2; ram_rlast = 1'b1;
            tick();
            ram_rvalid = 1'b0; ram_rlast = 1'b0;
            settle();
            n_tests++;
            if (m_rgnt !== 3'b000) begin
                n_fail++; $display("FAIL b2b_idle%0d got %b exp 000", k, m_rgnt);
            end
        end
        m_rreq = '0;
    endtask

    task automatic test_write_burst();
        bit   pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   beat;
        int   pulses;
        logic [2:0] ew;
        do_reset();
        m_wreq[0] = 1'b1;
        m_waddr[0 +: AW] = 32'h8000_0040;
        m_wlen[0 +: LW]  = 4'd3;
        m_wstrb[0 +: 4]  = 4'hF;
        m_wdata[0 +: DW] = 32'h0000_00D0;
        tick();
        settle();
        n_tests++;
        if ({ram_awvalid, ram_awlen, m_wgnt} !== {1'b1, 4'd3, 3'b001} || ram_awaddr !== 32'h8000_0040) begin
            n_fail++; $display("FAIL wr_cmd got v=%b len=%0d gnt=%b addr=%h exp v=1 len=3 gnt=001 addr=80000040",
                               ram_awvalid, ram_awlen, m_wgnt, ram_awaddr);
        end
        ram_awready = 1'b1;
        tick();
        ram_awready = 1'b0;
        beat = 0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            ram_wready = pat[k];
            m_wdata[0 +: DW] = 32'h0000_00D0 + 32'(beat);
            ew = pat[k] ? 3'b001 : 3'b000;
            settle();
            n_tests++;
            if (ram_wvalid !== 1'b1 || ram_wdata !== 32'h0000_00D0 + 32'(beat) || ram_wstrb !== 4'hF) begin
                n_fail++; $display("FAIL wr_data%0d got v=%b data=%h strb=%h exp v=1 data=%h strb=f",
                                   k, ram_wvalid, ram_wdata, ram_wstrb, 32'h0000_00D0 + 32'(beat));
            end
            n_tests++;
            if (ram_wlast !== (beat == 3) || m_wready !== ew) begin
                n_fail++; $display("FAIL wr_hs%0d got wlast=%b wready=%b exp wlast=%b wready=%b",
                                   k, ram_wlast, m_wready, (beat == 3), ew);
            end
            if (m_wready[0]) pulses++;
            if (pat[k]) beat++;
            tick();
        end
        ram_wready = 1'b0;
        settle();
        n_tests++;
        if (pulses !== 4 || ram_wvalid !== 1'b0 || m_wgnt !== 3'b001) begin
            n_fail++; $display("FAIL wr_resp got pulses=%0d wvalid=%b gnt=%b exp pulses=4 wvalid=0 gnt=001",
                               pulses, ram_wvalid, m_wgnt);
        end
        ram_bvalid = 1'b1;
        settle();
        n_tests++;
        if (m_bdone !== 3'b000) begin
            n_fail++; $display("FAIL wr_bdone_early got %b exp 000", m_bdone);
        end
        tick();
        ram_bvalid = 1'b0;
        settle();
        n_tests++;
        if (m_bdone !== 3'b001 || m_wgnt !== 3'b000) begin
            n_fail++; $display("FAIL wr_bdone got bdone=%b gnt=%b exp bdone=001 gnt=000", m_bdone, m_wgnt);
        end
        m_wreq = '0;
        tick();
        settle();
        n_tests++;
        if (m_bdone !== 3'b000 || m_wgnt !== 3'b000) begin
            n_fail++; $display("FAIL wr_after got bdone=%b gnt=%b exp 000 000", m_bdone, m_wgnt);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        m_wreq[0] = 1'b1;
        m_waddr[0 +: AW] = 32'h8000_1000;
        tick();
        ram_awready = 1'b1;
        tick();
        ram_awready = 1'b0;
        ram_wready  = 1'b1;
        tick();
        ram_wready = 1'b0;
        m_rreq = 3'b110;
        m_raddr[AW +: AW]   = 32'h8000_2000;
        m_raddr[2*AW +: AW] = 32'h8000_1008;
        tick();
        settle();
        n_tests++;
        if (m_rgnt !== 3'b010) begin
            n_fail++; $display("FAIL haz_gnt_p1 got %b exp 010", m_rgnt);
        end
        ram_arready = 1'b1;
        tick();
        ram_arready = 1'b0;
        ram_rvalid = 1'b1; ram_rid = 4'd1; ram_rlast = 1'b1;
        tick();
        ram_rvalid = 1'b0; ram_rlast = 1'b0;
        m_rreq[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            settle();
            n_tests++;
            if (m_rgnt !== 3'b000) begin
                n_fail++; $display("FAIL haz_block%0d got %b exp 000", k, m_rgnt);
            end
        end
        ram_bvalid = 1'b1;
        tick();
        ram_bvalid = 1'b0;
        settle();
        n_tests++;
        if (m_bdone !== 3'b001 || m_rgnt !== 3'b000) begin
            n_fail++; $display("FAIL haz_bdone got bdone=%b rgnt=%b exp 001 000", m_bdone, m_rgnt);
        end
        m_wreq = '0;
        tick();
        settle();
        n_tests++;
        if (m_rgnt !== 3'b100) begin
            n_fail++; $display("FAIL haz_gnt_p2 got %b exp 100", m_rgnt);
        end
        ram_arready = 1'b1;
        tick();
        ram_arready = 1'b0;
        ram_rvalid = 1'b1; ram_rid = 4'd2; ram_rlast = 1'b1;
        tick();
        ram_rvalid = 1'b0; ram_rlast = 1'b0;
        m_rreq = '0;
        // Same-cycle read and write to one line: write must win.
        m_wreq[1] = 1'b1;
        m_waddr[AW +: AW] = 32'h8000_3000;
        m_rreq[0] = 1'b1;
        m_raddr[0 +: AW] = 32'h8000_3004;
        tick();
        settle();
        n_tests++;
        if (m_wgnt !== 3'b010 || m_rgnt !== 3'b000) begin
            n_fail++; $display("FAIL haz_same got wgnt=%b rgnt=%b exp 010 000", m_wgnt, m_rgnt);
        end
        ram_awready = 1'b1;
        tick();
        ram_awready = 1'b0;
        ram_wready  = 1'b1;
        settle();
        n_tests++;
        if (m_rgnt !== 3'b000) begin
            n_fail++; $display("FAIL haz_same_hold got %b exp 000", m_rgnt);
        end
        tick();
        ram_wready = 1'b0;
        ram_bvalid = 1'b1;
        tick();
        ram_bvalid = 1'b0;
        m_wreq = '0;
        tick();
        settle();
        n_tests++;
        if (m_rgnt !== 3'b001) begin
            n_fail++; $display("FAIL haz_same_rel got %b exp 001", m_rgnt);
        end
        m_rreq = '0;
    endtask

    task automatic test_stray_rid();
        do_reset();
        m_rreq[0] = 1'b1;
        m_raddr[0 +: AW] = 32'h0000_0100;
        m_rlen[0 +: LW] = 4'd1;
        tick();
        ram_arready = 1'b1;
        tick();
        ram_arready = 1'b0;
        ram_rvalid = 1'b1; ram_rid = 4'd3; ram_rlast = 1'b1; ram_rdata = 32'h0000_0BAD;
        settle();
        n_tests++;
        if (m_rvalid !== 3'b000 || m_rlast !== 3'b000) begin
            n_fail++; $display("FAIL stray_drop got rvalid=%b rlast=%b exp 000 000", m_rvalid, m_rlast);
        end
        tick();
        ram_rid = 4'd0; ram_rlast = 1'b0; ram_rdata = 32'h0000_0011;
        settle();
        n_tests++;
        if (m_rvalid !== 3'b001 || m_rdata !== 32'h0000_0011 || m_rgnt !== 3'b001) begin
            n_fail++; $display("FAIL stray_fwd got rvalid=%b data=%h gnt=%b exp 001 00000011 001",
                               m_rvalid, m_rdata, m_rgnt);
        end
        tick();
        ram_rlast = 1'b1; ram_rdata = 32'h0000_0022;
        settle();
        n_tests++;
        if (m_rlast !== 3'b001) begin
            n_fail++; $display("FAIL stray_last got %b exp 001", m_rlast);
        end
        tick();
        ram_rvalid = 1'b0; ram_rlast = 1'b0;
        m_rreq = '0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        m_rreq[1] = 1'b1;
        m_raddr[AW +: AW] = 32'h0000_0200;
        m_rlen[LW +: LW] = 4'd3;
        m_wreq[2] = 1'b1;
        m_waddr[2*AW +: AW] = 32'h0000_0300;
        m_wlen[2*LW +: LW] = 4'd3;
        m_wdata[2*DW +: DW] = 32'h5555_AAAA;
        tick();
        ram_arready = 1'b1;
        ram_awready = 1'b1;
        tick();
        ram_arready = 1'b0;
        ram_awready = 1'b0;
        ram_rvalid = 1'b1; ram_rid = 4'd1; ram_rdata = 32'h1234_5678;
        ram_wready = 1'b1;
        settle();
        n_tests++;
        if (m_rvalid !== 3'b010 || ram_wvalid !== 1'b1 || m_wgnt !== 3'b100) begin
            n_fail++; $display("FAIL rstmid_pre got rvalid=%b wvalid=%b wgnt=%b exp 010 1 100",
                               m_rvalid, ram_wvalid, m_wgnt);
        end
        rst = 1'b1;
        m_rreq = '0;
        m_wreq = '0;
        ram_rlast = 1'b1;
        ram_bvalid = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        n_tests++;
        if ({m_rgnt, m_wgnt, m_rvalid, m_rlast, m_wready, m_bdone} !== 18'b0) begin
            n_fail++; $display("FAIL rstmid_client got %b exp 0",
                               {m_rgnt, m_wgnt, m_rvalid, m_rlast, m_wready, m_bdone});
        end
        n_tests++;
        if ({ram_arvalid, ram_awvalid, ram_wvalid, ram_wlast} !== 4'b0 || m_rdata !== '0 || ram_wdata !== '0) begin
            n_fail++; $display("FAIL rstmid_ram got v=%b rdata=%h wdata=%h exp 0000 0 0",
                               {ram_arvalid, ram_awvalid, ram_wvalid, ram_wlast}, m_rdata, ram_wdata);
        end
        tick();
        settle();
        n_tests++;
        if (m_bdone !== 3'b000 || m_rlast !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_nodone got bdone=%b rlast=%b exp 000 000", m_bdone, m_rlast);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_write_burst();
        test_hazard();
        test_stray_rid();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-to-1 memory-port arbiter; successor to the fixed two-way cached/uncached mux.
- Sits between the CPU-side memory clients (icache, dcache, uncached/confreg path, …) and the single AXI-like RAM port.
- Independent read and write channels, each with round-robin arbitration, grant held for a whole burst, and beat-level handshakes.
- Read-after-write address hazard interlock between the two channels.

Parameters:
NUM_PORTS, 3, number of client ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
LEN_W, 4, burst length field width (beats = len+1)
HAZ_LSB, 4, low address bit used for the read/write hazard compare (line granularity)

Ports:
clk  in  1  clock
rst  in  1  reset
m_rreq  in  NUM_PORTS  per-port read request, held until m_rlast for that port
m_raddr  in  NUM_PORTS*ADDR_W  read address, port i at slice i
m_rsize  in  NUM_PORTS*3  read beat size
m_rlen  in  NUM_PORTS*LEN_W  read burst length
m_rgnt  out  NUM_PORTS  one-hot read owner
m_rvalid  out  NUM_PORTS  read beat valid for port i
m_rlast  out  NUM_PORTS  last read beat for port i
m_rdata  out  DATA_W  shared read data
m_wreq  in  NUM_PORTS  per-port write request, held until m_bdone
m_waddr  in  NUM_PORTS*ADDR_W  write address
m_wsize  in  NUM_PORTS*3  write beat size
m_wlen  in  NUM_PORTS*LEN_W  write burst length
m_wdata  in  NUM_PORTS*DATA_W  write data for current beat
m_wstrb  in  NUM_PORTS*4  write byte strobes
m_wgnt  out  NUM_PORTS  one-hot write owner
m_wready  out  NUM_PORTS  write beat accepted; client advances to next beat
m_bdone  out  NUM_PORTS  one-cycle write-complete pulse
ram_arvalid/ram_arready  out/in  1  read address handshake
ram_araddr, ram_arsize, ram_arlen, ram_arid  out  ADDR_W,3,LEN_W,4  read command; arid = owner index
ram_rvalid, ram_rlast, ram_rid, ram_rdata  in  1,1,4,DATA_W  read beat
ram_awvalid/ram_awready  out/in  1  write address handshake
ram_awaddr, ram_awsize, ram_awlen  out  ADDR_W,3,LEN_W  write command
ram_wvalid/ram_wready  out/in  1  write data handshake
ram_wlast, ram_wdata, ram_wstrb  out  1,DATA_W,4  write beat
ram_bvalid  in  1  write response

Behaviour:
- Reset: rst is synchronous, active-high, sampled on the rising edge of clk.
  - On reset: all outputs 0, both FSMs IDLE, both round-robin pointers 0, beat counter 0.
  - Reset mid-burst abandons the transaction with no completion pulse.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: choose the first requesting port at or after rr_ptr_r, wrapping mod NUM_PORTS.
  - On grant: latch owner, addr, size and len; set m_rgnt; go to R_ADDR the next cycle.
  - R_ADDR: ram_arvalid=1 until ram_arready, then R_DATA.
  - R_DATA: beat accepted when ram_rvalid and ram_rid==owner.
  - Beats with a mismatching rid are dropped; m_rvalid stays 0 for them.
  - m_rdata=ram_rdata and m_rvalid[owner]=1 are combinational, same cycle as the beat.
  - Beat with ram_rlast: m_rlast[owner]=1 that cycle, clear m_rgnt, rr_ptr_r=owner+1 mod N, go to R_IDLE.
  - Minimum latency: request at cycle t -> ram_arvalid at t+1.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE, with the same round-robin and latching rules.
  - W_DATA: ram_wvalid=1; ram_wdata/ram_wstrb taken combinationally from the owner slice.
  - m_wready[owner] = ram_wvalid & ram_wready.
  - Beat counter increments per accepted beat; ram_wlast=1 when count==latched len; count wraps to 0 after the last beat.
  - After the last beat go to W_RESP.
  - W_RESP: on ram_bvalid, pulse m_bdone[owner] for one cycle, clear m_wgnt, advance pointer, go to W_IDLE.
- Hazard interlock: a read candidate is masked while the write FSM is non-IDLE and raddr[ADDR_W-1:HAZ_LSB]==latched waddr[ADDR_W-1:HAZ_LSB].
  - Arbitration continues among the other requesters.
  - A same-cycle read and write grant to the same line: the write wins; the read waits.
- Arbitration occurs only in IDLE. Requests dropped before grant are ignored.
- A single requester is re-granted back-to-back with one IDLE cycle between bursts.
- Read and write channels operate concurrently; a port may own both channels at once.

Test Plan:
- Single read: port1 rreq, raddr=0x1FC00010, rlen=3; ram returns 4 beats rid=1 -> arvalid at t+1, arid=1, m_rvalid[1] for 4 beats, m_rlast[1] on the 4th beat, m_rgnt=0 the next cycle.
- Round-robin: ports 0,1,2 rreq held continuously, len=0 -> grants in order 0,1,2,0, never starving any port.
- Write burst: port0 wlen=3, ram_wready toggling 1,0,1,1,0,1 -> 4 m_wready pulses, wlast on beat 4 only, m_bdone[0] one cycle after bvalid.
- Hazard: port0 writing 0x80001000 in W_RESP, port2 reads 0x80001008 while port1 reads 0x80002000 -> port1 granted; port2 granted only after m_bdone.
- Stray rid: in R_DATA, owner=0, inject beat rid=3 -> no m_rvalid; the later rid=0 beat is forwarded.
- Reset mid-op: assert rst during R_DATA and W_DATA -> next cycle all outputs 0, both FSMs IDLE, no m_rlast/m_bdone.
